// File: rtl/imem_axi_loader.sv
// AXI4-Lite slave that loads and reads back instruction memory.
// One transaction at a time; writes take priority over reads.
module imem_axi_loader #(
   parameter int WORD_AW = 12,
   parameter int AXI_AW  = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AXI_AW-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [AXI_AW-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic              mem_we,
   output logic [WORD_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE,
      WR_WAIT,
      WR_EXEC,
      WR_RESP,
      RD_WAIT,
      RD_CAPT,
      RD_RESP
   } state_t;

   state_t state;
   state_t state_nx;

   logic              aw_lat;
   logic              w_lat;
   logic [AXI_AW-1:0] awaddr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;

   logic wr_accept;
   logic aw_hs;
   logic w_hs;
   logic ar_hs;
   logic have_aw;
   logic have_w;
   logic wr_ok;

   assign wr_accept = (state == IDLE) || (state == WR_WAIT);

   // Readies are gated by rst so every output reads zero during reset.
   assign s_axi_awready = !rst && wr_accept && !aw_lat;
   assign s_axi_wready  = !rst && wr_accept && !w_lat;
   assign s_axi_arready = !rst && (state == IDLE)
                          && !s_axi_awvalid && !s_axi_wvalid;

   assign aw_hs   = s_axi_awvalid && s_axi_awready;
   assign w_hs    = s_axi_wvalid && s_axi_wready;
   assign ar_hs   = s_axi_arvalid && s_axi_arready;
   assign have_aw = aw_lat || aw_hs;
   assign have_w  = w_lat || w_hs;

   assign wr_ok = (wstrb_q == 4'hF) && (awaddr_q[1:0] == 2'b00);

   assign s_axi_rresp = 2'b00;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (have_aw && have_w) begin
               state_nx = WR_EXEC;
            end else if (have_aw || have_w) begin
               state_nx = WR_WAIT;
            end else if (ar_hs) begin
               state_nx = RD_WAIT;
            end
         end
         WR_WAIT: begin
            if (have_aw && have_w) begin
               state_nx = WR_EXEC;
            end
         end
         WR_EXEC: state_nx = WR_RESP;
         WR_RESP: begin
            if (s_axi_bvalid && s_axi_bready) begin
               state_nx = IDLE;
            end
         end
         RD_WAIT: state_nx = RD_CAPT;
         RD_CAPT: state_nx = RD_RESP;
         RD_RESP: begin
            if (s_axi_rvalid && s_axi_rready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_lat       <= 1'b0;
         w_lat        <= 1'b0;
         awaddr_q     <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= 2'b00;
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
      end else begin
         mem_we <= 1'b0;
         if (aw_hs) begin
            aw_lat   <= 1'b1;
            awaddr_q <= s_axi_awaddr;
         end
         if (w_hs) begin
            w_lat   <= 1'b1;
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
         end
         case (state)
            IDLE: begin
               if (ar_hs) begin
                  mem_addr <= s_axi_araddr[AXI_AW-1:2];
               end
            end
            WR_EXEC: begin
               aw_lat       <= 1'b0;
               w_lat        <= 1'b0;
               s_axi_bvalid <= 1'b1;
               // Partial or misaligned writes are refused with SLVERR.
               s_axi_bresp  <= wr_ok ? 2'b00 : 2'b10;
               if (wr_ok) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= awaddr_q[AXI_AW-1:2];
                  mem_wdata <= wdata_q;
               end
            end
            WR_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid <= 1'b0;
                  s_axi_bresp  <= 2'b00;
               end
            end
            RD_CAPT: begin
               s_axi_rdata  <= mem_rdata;
               s_axi_rvalid <= 1'b1;
            end
            RD_RESP: begin
               if (s_axi_rready) begin
                  s_axi_rvalid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_axi_loader.sv
// Directed bench for imem_axi_loader with a small registered memory.
// Vector tables for plain writes/reads, hand sequences for corner cases.
module tb_imem_axi_loader;

   logic        clk;
   logic        rst;
   logic [13:0] s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [13:0] s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int we_count = 0;
   logic [11:0] last_addr = '0;
   logic [31:0] last_data = '0;

   logic [31:0] mem [0:4095] = '{default: 32'h0};

   imem_axi_loader #(.WORD_AW(12), .AXI_AW(14)) dut (
      .clk(clk), .rst(rst),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid),
      .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         we_count  <= we_count + 1;
         last_addr <= mem_addr;
         last_data <= mem_wdata;
      end
   end

   typedef struct {
      logic [13:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic        exp_we;
      logic [1:0]  exp_resp;
   } wr_vec_t;

   typedef struct {
      logic [13:0] addr;
      logic [31:0] exp;
      int          hold;
   } rd_vec_t;

   wr_vec_t wv [5];
   rd_vec_t rv [8];

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timeout waiting on DUT", name);
   endtask

   function automatic logic [127:0] out_vec();
      return {41'd0, s_axi_awready, s_axi_wready, s_axi_arready,
              s_axi_bvalid, s_axi_bresp, s_axi_rvalid, s_axi_rresp,
              s_axi_rdata, mem_we, mem_addr, mem_wdata, busy};
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic write_finish(input string name, input int n0,
                               input logic exp_we, input logic [1:0] exp_resp,
                               input logic [11:0] exp_addr,
                               input logic [31:0] exp_data);
      int lat = 0;
      do begin
         tick();
         lat++;
      end while (!s_axi_bvalid && lat < 20);
      if (!s_axi_bvalid) begin
         timeout({name, "_b"});
         return;
      end
      check({name, "_blat"}, lat, 2);
      check({name, "_bresp"}, s_axi_bresp, exp_resp);
      s_axi_bready = 1'b1;
      @(posedge clk);
      #1;
      s_axi_bready = 1'b0;
      check({name, "_wecnt"}, we_count - n0, exp_we ? 1 : 0);
      if (exp_we) check({name, "_mem"}, {last_addr, last_data},
                        {exp_addr, exp_data});
      tick();
      check({name, "_idle"}, {s_axi_bvalid, busy}, 2'b00);
   endtask

   task automatic do_write(input string name, input logic [13:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input logic exp_we, input logic [1:0] exp_resp);
      int n0 = we_count;
      int k = 0;
      tick();
      s_axi_awaddr = addr;
      s_axi_wdata = data;
      s_axi_wstrb = strb;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid = 1'b1;
      #1;
      while (!(s_axi_awready && s_axi_wready) && k < 20) begin
         tick();
         k++;
      end
      if (k >= 20) timeout({name, "_awready"});
      @(posedge clk);
      #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid = 1'b0;
      write_finish(name, n0, exp_we, exp_resp, addr[13:2], data);
   endtask

   task automatic write_split(input string name, input logic w_first,
                              input logic [13:0] addr, input logic [31:0] data);
      int n0 = we_count;
      tick();
      s_axi_awaddr = addr;
      s_axi_wdata = data;
      s_axi_wstrb = 4'hF;
      if (w_first) s_axi_wvalid = 1'b1;
      else s_axi_awvalid = 1'b1;
      #1;
      check({name, "_first_rdy"}, w_first ? s_axi_wready : s_axi_awready, 1);
      @(posedge clk);
      #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid = 1'b0;
      for (int g = 0; g < 2; g++) begin
         tick();
         check({name, "_wait"}, {busy, s_axi_awready, s_axi_wready},
               w_first ? 3'b110 : 3'b101);
         check({name, "_nowe"}, we_count - n0, 0);
      end
      tick();
      if (w_first) s_axi_awvalid = 1'b1;
      else s_axi_wvalid = 1'b1;
      #1;
      check({name, "_second_rdy"}, w_first ? s_axi_awready : s_axi_wready, 1);
      @(posedge clk);
      #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid = 1'b0;
      write_finish(name, n0, 1'b1, 2'b00, addr[13:2], data);
   endtask

   task automatic read_finish(input string name, input logic [31:0] exp,
                              input int hold);
      int lat = 0;
      do begin
         tick();
         lat++;
      end while (!s_axi_rvalid && lat < 20);
      if (!s_axi_rvalid) begin
         timeout({name, "_r"});
         return;
      end
      check({name, "_rlat"}, lat, 3);
      check({name, "_rdata"}, {s_axi_rresp, s_axi_rdata}, {2'b00, exp});
      for (int i = 0; i < hold; i++) begin
         tick();
         check({name, "_hold"}, {s_axi_rvalid, s_axi_rdata}, {1'b1, exp});
      end
      s_axi_rready = 1'b1;
      @(posedge clk);
      #1;
      s_axi_rready = 1'b0;
      tick();
      check({name, "_idle"}, {s_axi_rvalid, busy}, 2'b00);
   endtask

   task automatic start_read(input string name, input logic [13:0] addr);
      int k = 0;
      tick();
      s_axi_araddr = addr;
      s_axi_arvalid = 1'b1;
      #1;
      while (!s_axi_arready && k < 20) begin
         tick();
         k++;
      end
      if (k >= 20) timeout({name, "_arready"});
      @(posedge clk);
      #1;
      s_axi_arvalid = 1'b0;
   endtask

   task automatic do_read(input string name, input logic [13:0] addr,
                          input logic [31:0] exp, input int hold);
      start_read(name, addr);
      read_finish(name, exp, hold);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n0;
      int k;
      logic b_done;

      wv[0] = '{14'h0100, 32'h12345678, 4'hF, 1'b1, 2'b00};
      wv[1] = '{14'h0004, 32'hA5A5A5A5, 4'hF, 1'b1, 2'b00};
      wv[2] = '{14'h0200, 32'hCAFEF00D, 4'h3, 1'b0, 2'b10};
      wv[3] = '{14'h0002, 32'h11111111, 4'hF, 1'b0, 2'b10};
      wv[4] = '{14'h0008, 32'h00000001, 4'hF, 1'b1, 2'b00};

      rv[0] = '{14'h0100, 32'h12345678, 5};
      rv[1] = '{14'h0004, 32'hA5A5A5A5, 0};
      rv[2] = '{14'h0200, 32'h00000000, 0};
      rv[3] = '{14'h0000, 32'h00000000, 0};
      rv[4] = '{14'h000B, 32'h00000001, 0};
      rv[5] = '{14'h0010, 32'hDEADBEEF, 0};
      rv[6] = '{14'h3FFC, 32'h600DCAFE, 2};
      rv[7] = '{14'h0023, 32'h13579BDF, 0};

      rst = 1'b1;
      s_axi_awaddr = '0;
      s_axi_awvalid = 1'b0;
      s_axi_wdata = '0;
      s_axi_wstrb = '0;
      s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b0;
      s_axi_araddr = '0;
      s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0;
      #1;
      check("rst_outputs", out_vec(), 128'd0);
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check("rst_release_rdy",
            {s_axi_awready, s_axi_wready, s_axi_arready, busy}, 4'b1110);

      do_write("wr_same", 14'h0010, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00);
      write_split("wr_wfirst", 1'b1, 14'h3FFC, 32'h600DCAFE);
      write_split("wr_awfirst", 1'b0, 14'h0020, 32'h13579BDF);

      for (int i = 0; i < 5; i++)
         do_write($sformatf("wr_vec%0d", i), wv[i].addr, wv[i].data,
                  wv[i].strb, wv[i].exp_we, wv[i].exp_resp);
      for (int i = 0; i < 8; i++)
         do_read($sformatf("rd_vec%0d", i), rv[i].addr, rv[i].exp,
                 rv[i].hold);

      n0 = we_count;
      tick();
      s_axi_awaddr = 14'h0100;
      s_axi_wdata = 32'h0BADF00D;
      s_axi_wstrb = 4'hF;
      s_axi_araddr = 14'h0100;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid = 1'b1;
      s_axi_arvalid = 1'b1;
      #1;
      check("prio_arready", s_axi_arready, 1'b0);
      check("prio_wready", {s_axi_awready, s_axi_wready}, 2'b11);
      @(posedge clk);
      #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b1;
      b_done = 1'b0;
      k = 0;
      tick();
      while (!s_axi_arready && k < 20) begin
         if (s_axi_bvalid) b_done = 1'b1;
         tick();
         k++;
      end
      if (k >= 20) timeout("prio_arready_rise");
      s_axi_bready = 1'b0;
      check("prio_b_before_ar", {b_done, s_axi_bvalid}, 2'b10);
      check("prio_wecnt", we_count - n0, 1);
      @(posedge clk);
      #1;
      s_axi_arvalid = 1'b0;
      read_finish("prio_rd", 32'h0BADF00D, 0);

      n0 = we_count;
      tick();
      s_axi_wdata = 32'hFFFF0000;
      s_axi_wstrb = 4'hF;
      s_axi_wvalid = 1'b1;
      @(posedge clk);
      #1;
      s_axi_wvalid = 1'b0;
      tick();
      check("rst_wr_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("rst_wr_outputs", out_vec(), 128'd0);
      tick();
      rst = 1'b0;
      #1;
      check("rst_wr_rdy",
            {s_axi_awready, s_axi_wready, s_axi_arready, busy}, 4'b1110);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_wr_quiet", {s_axi_bvalid, busy}, 2'b00);
      end
      check("rst_wr_nowe", we_count - n0, 0);
      do_write("post_rst_wr", 14'h0300, 32'h77777777, 4'hF, 1'b1, 2'b00);

      start_read("rst_rd", 14'h0100);
      tick();
      tick();
      check("rst_rd_busy", {busy, s_axi_rvalid}, 2'b10);
      rst = 1'b1;
      #1;
      check("rst_rd_outputs", out_vec(), 128'd0);
      tick();
      rst = 1'b0;
      #1;
      check("rst_rd_rdy",
            {s_axi_awready, s_axi_wready, s_axi_arready, busy}, 4'b1110);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_rd_quiet", {s_axi_rvalid, busy}, 2'b00);
      end
      do_read("post_rst_rd", 14'h0300, 32'h77777777, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
